ifu: RTL and testbench
======================

// Module: ifu
// PURPOSE
//  Instruction fetch stage; sits directly upstream of the decoder and feeds it one 32-bit instruction at a time.
//  Holds the PC and fetches over a read-address/read-data handshake (ar*/r*) to instruction memory.
//  Presents inst/inst_pc to decode with a valid/ready handshake.
//  Non-pipelined: one instruction in flight; the next fetch starts only after downstream returns npc via npc_valid.
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC loaded on reset; first fetch address
//  EBREAK    32'h0010_0073  instruction substituted on fetch error (ends simulation)
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   synchronous reset, active-high
//  araddr      out  32  fetch address (= pc)
//  arvalid     out  1   read-address valid
//  arready     in   1   memory accepts address
//  rdata       in   32  read data (instruction word)
//  rresp       in   2   read response, 2'b00 = OKAY, else error
//  rvalid      in   1   read data valid
//  rready      out  1   ifu accepts read data
//  inst        out  32  instruction to decode
//  inst_pc     out  32  PC of inst
//  inst_valid  out  1   inst/inst_pc valid
//  inst_ready  in   1   decode accepts inst
//  npc         in   32  next PC from execute/writeback
//  npc_valid   in   1   npc valid, single-cycle pulse
//  fetch_err   out  1   sticky error flag: bad rresp or misaligned npc
//  fetch_cnt   out  32  count of instructions accepted by decode, wraps
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, inst=0, fetch_err=0, fetch_cnt=0.
//   All handshake outputs are 0 while in IDLE. araddr=pc and inst_pc=pc always.
//  FSM, one transition per clk:
//   IDLE -> REQ unconditionally.
//   REQ: arvalid=1. araddr is held stable until arready=1. On arready -> RESP.
//   RESP: rready=1. On rvalid: inst<=(rresp==0)?rdata:EBREAK. Set fetch_err if rresp!=0. -> OUT.
//   OUT: inst_valid=1. inst/inst_pc are held stable until inst_ready=1.
//    On inst_ready: fetch_cnt+=1 (mod 2^32) -> WAIT.
//   WAIT: on npc_valid: pc<=npc.
//    If npc[1:0]==0 -> REQ.
//    Else inst<=EBREAK, fetch_err<=1 -> OUT, with no memory request.
//  arvalid, rready and inst_valid are decoded from state only; no combinational path from any input.
//  Minimum latency, assuming arready and rvalid are each high on first opportunity:
//   reset deassert to inst_valid = 3 cycles (IDLE, REQ, RESP).
//   npc_valid to inst_valid = 3 cycles (WAIT, REQ, RESP).
//  Boundaries:
//   - npc_valid outside WAIT is ignored; pc is unchanged.
//   - rvalid outside RESP is ignored (rready=0).
//   - arready outside REQ is ignored.
//   - rvalid in the same cycle arready is accepted is not consumed; it must be re-presented in RESP.
//   - fetch_err stays set until rst; fetching continues normally after an error.
//   - Reset mid-transaction (REQ/RESP/OUT/WAIT) returns to IDLE immediately.
//     An outstanding memory response is then dropped; the memory model must tolerate this.
//   - pc wraps modulo 2^32; npc=32'hFFFF_FFFC is legal.
// TESTING
//  1. Reset, arready=1, rvalid=1 with rdata=32'h00000513, inst_ready=1 -> arvalid in cycle 1, araddr=32'h8000_0000.
//     inst_valid in cycle 3 with inst=32'h00000513; fetch_cnt=1.
//  2. Backpressure: arready low 4 cycles, rvalid low 3 cycles, inst_ready low 2 cycles
//     -> araddr, inst and inst_pc stable throughout; exactly one fetch_cnt increment.
//  3. npc_valid with npc=32'h8000_0010 in WAIT -> next araddr=32'h8000_0010, inst_pc=32'h8000_0010.
//     npc_valid pulsed in OUT -> no pc change.
//  4. rresp=2'b10 on a fetch -> inst=32'h0010_0073, fetch_err=1.
//     Next fetch with rresp=0 delivers rdata; fetch_err stays 1.
//  5. npc=32'h8000_0006 -> no arvalid; inst_valid with inst=32'h0010_0073, inst_pc=32'h8000_0006, fetch_err=1.
//  6. Assert rst while in RESP with rvalid pending -> next cycle IDLE, pc=32'h8000_0000, fetch_cnt=0.
//     The stale rvalid is ignored.

Source files
------------

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ifu
//  Purpose  : Non-pipelined instruction fetch stage. Holds the PC and fetches
//             one word over an ar/r handshake, then hands it to decode.
//  Revision : 1.0  initial release
// ============================================================================
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] EBREAK   = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RESP = 3'd2,
        S_OUT  = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_fetch_cnt;
    logic        r_fetch_err;
    logic        w_npc_aligned;

    assign w_npc_aligned = (npc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_inst      <= '0;
            r_fetch_err <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_RESP && rvalid) begin
                r_inst <= (rresp == 2'b00) ? rdata : EBREAK;
                if (rresp != 2'b00) begin
                    r_fetch_err <= 1'b1;
                end
            end
            if (r_state == S_OUT && inst_ready) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            // A misaligned target never reaches memory; decode sees EBREAK instead.
            if (r_state == S_WAIT && npc_valid) begin
                r_pc <= npc;
                if (!w_npc_aligned) begin
                    r_inst      <= EBREAK;
                    r_fetch_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        arvalid     = 1'b0;
        rready      = 1'b0;
        inst_valid  = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                arvalid = 1'b1;
                if (arready) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rready = 1'b1;
                if (rvalid) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                inst_valid = 1'b1;
                if (inst_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (npc_valid) w_state_nxt = w_npc_aligned ? S_REQ : S_OUT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign araddr    = r_pc;
    assign inst_pc   = r_pc;
    assign inst      = r_inst;
    assign fetch_err = r_fetch_err;
    assign fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifu
//  Purpose  : Self-checking bench for ifu: directed scenarios followed by
//             randomized traffic against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifu;

    localparam logic [31:0] C_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] C_EBREAK   = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] npc = '0;
    logic        npc_valid = 1'b0;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ifu dut (
        .clk        (clk),
        .rst        (rst),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .npc        (npc),
        .npc_valid  (npc_valid),
        .fetch_err  (fetch_err),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: which handshake the fetch unit currently owes.
    typedef enum int {P_IDLE, P_ADDR, P_DATA, P_DELIVER, P_AWAIT} phase_t;
    phase_t      m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_err;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic ar, input logic rv,
                              input logic [31:0] rd, input logic [1:0] rr,
                              input logic ir, input logic nv, input logic [31:0] np);
        if (r) begin
            m_phase = P_IDLE;
            m_pc    = C_RESET_PC;
            m_inst  = 32'd0;
            m_err   = 1'b0;
            m_cnt   = 32'd0;
        end else begin
            case (m_phase)
                P_IDLE:    m_phase = P_ADDR;
                P_ADDR:    if (ar) m_phase = P_DATA;
                P_DATA: if (rv) begin
                    m_inst  = (rr == 2'b00) ? rd : C_EBREAK;
                    m_err   = m_err | (rr != 2'b00);
                    m_phase = P_DELIVER;
                end
                P_DELIVER: if (ir) begin
                    m_cnt   = m_cnt + 32'd1;
                    m_phase = P_AWAIT;
                end
                P_AWAIT: if (nv) begin
                    m_pc = np;
                    if (np % 4 == 0) begin
                        m_phase = P_ADDR;
                    end else begin
                        m_inst  = C_EBREAK;
                        m_err   = 1'b1;
                        m_phase = P_DELIVER;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("arvalid",    32'(arvalid),    32'(m_phase == P_ADDR));
        chk("rready",     32'(rready),     32'(m_phase == P_DATA));
        chk("inst_valid", 32'(inst_valid), 32'(m_phase == P_DELIVER));
        chk("araddr",     araddr,          m_pc);
        chk("inst_pc",    inst_pc,         m_pc);
        chk("inst",       inst,            m_inst);
        chk("fetch_err",  32'(fetch_err),  32'(m_err));
        chk("fetch_cnt",  fetch_cnt,       m_cnt);
    endtask

    // One clock: apply inputs, advance, update the model, compare away from the edge.
    task automatic cyc(input logic r, input logic ar, input logic rv,
                       input logic [31:0] rd, input logic [1:0] rr,
                       input logic ir, input logic nv, input logic [31:0] np);
        rst = r; arready = ar; rvalid = rv; rdata = rd; rresp = rr;
        inst_ready = ir; npc_valid = nv; npc = np;
        @(posedge clk);
        #1;
        model_step(r, ar, rv, rd, rr, ir, nv, np);
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] tmp;
        logic [31:0] np;
        logic [31:0] cnt0;

        m_phase = P_IDLE;
        m_pc    = C_RESET_PC;
        m_inst  = '0;
        m_err   = 1'b0;
        m_cnt   = '0;

        // Basic fetch from reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        cyc(0, 1, 1, 32'h0000_0513, 0, 1, 0, 0);
        chk("t1_arvalid_c1", 32'(arvalid), 32'd1);
        chk("t1_araddr", araddr, 32'h8000_0000);
        cyc(0, 1, 1, 32'h0000_0513, 0, 1, 0, 0);
        cyc(0, 1, 1, 32'h0000_0513, 0, 1, 0, 0);
        chk("t1_valid_c3", 32'(inst_valid), 32'd1);
        chk("t1_inst", inst, 32'h0000_0513);
        cyc(0, 1, 1, 32'h0000_0513, 0, 1, 0, 0);
        chk("t1_cnt", fetch_cnt, 32'd1);

        // Redirect in WAIT, ignored npc in OUT
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h8000_0010);
        chk("t3_araddr", araddr, 32'h8000_0010);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h1111_2222, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
        chk("t3_inst_pc_held", inst_pc, 32'h8000_0010);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);

        // Backpressure on every handshake
        cnt0 = fetch_cnt;
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h8000_0020);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 32'hBAD0_0000, 0, 1, 0, 0);
            chk("t2_araddr_hold", araddr, 32'h8000_0020);
        end
        cyc(0, 1, 1, 32'hBAD0_0001, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 32'hBAD0_0002, 0, 1, 0, 0);
        end
        cyc(0, 0, 1, 32'hCAFE_F00D, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 1, 32'hBAD0_0003, 0, 0, 0, 0);
            chk("t2_inst_hold", inst, 32'hCAFE_F00D);
            chk("t2_pc_hold", inst_pc, 32'h8000_0020);
        end
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t2_cnt_once", fetch_cnt, cnt0 + 32'd1);

        // Misaligned redirect skips memory
        cyc(0, 1, 1, 0, 0, 0, 1, 32'h8000_0006);
        chk("t5_no_arvalid", 32'(arvalid), 32'd0);
        chk("t5_inst", inst, C_EBREAK);
        chk("t5_inst_pc", inst_pc, 32'h8000_0006);
        chk("t5_err", 32'(fetch_err), 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);

        // Bus error after reset, then a clean fetch
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h0000_0513, 2'b10, 0, 0, 0);
        chk("t4_inst_ebreak", inst, C_EBREAK);
        chk("t4_err", 32'(fetch_err), 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h8000_0004);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
        chk("t4_inst_ok", inst, 32'hDEAD_BEEF);
        chk("t4_err_sticky", 32'(fetch_err), 32'd1);

        // Reset while a response is pending
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h8000_0040);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h5555_AAAA, 0, 0, 0, 0);
        chk("t6_pc", araddr, C_RESET_PC);
        chk("t6_cnt", fetch_cnt, 32'd0);
        chk("t6_rready", 32'(rready), 32'd0);
        cyc(0, 0, 1, 32'h5555_AAAA, 0, 0, 0, 0);
        chk("t6_stale_inst", inst, 32'd0);

        // Wrap-around target
        cyc(0, 1, 1, 32'h0000_0001, 0, 1, 0, 0);
        cyc(0, 1, 1, 32'h0000_0001, 0, 1, 0, 0);
        cyc(0, 1, 1, 32'h0000_0001, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        chk("wrap_araddr", araddr, 32'hFFFF_FFFC);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tmp = $urandom;
            case ($urandom_range(0, 9))
                0:       np = 32'hFFFF_FFFC;
                1:       np = {tmp[31:2], 2'($urandom_range(1, 3))};
                default: np = {tmp[31:2], 2'b00};
            endcase
            cyc(($urandom_range(0, 299) == 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                $urandom,
                ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0),
                np);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
